// File: rtl/counter_sweep_ctrl.sv
// counter_sweep_ctrl: drives an external up/down counter through numSweeps lo->hi->lo sweeps.
module counter_sweep_ctrl #(
  parameter int WIDTH   = 8,
  parameter int SWEEP_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [WIDTH-1:0]   loLimit,
  input  logic [WIDTH-1:0]   hiLimit,
  input  logic [SWEEP_W-1:0] numSweeps,
  input  logic [WIDTH-1:0]   countIn,
  output logic               enable,
  output logic               upDown,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [SWEEP_W-1:0] sweepCnt
);
  localparam logic [2:0] IDLE = 3'd0, SEEK = 3'd1, UP = 3'd2, DOWN = 3'd3, DONE = 3'd4;
  logic [2:0] state;
  logic [WIDTH-1:0] lo, hi;
  logic [SWEEP_W-1:0] nsw, cnt_nxt;
  logic ok;
  assign ok = loLimit < hiLimit && numSweeps != '0;
  assign cnt_nxt = sweepCnt + 1'b1;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      lo <= '0;
      hi <= '0;
      nsw <= '0;
      sweepCnt <= '0;
      error <= 1'b0;
    end else begin
      error <= state == IDLE && start && !abort && !ok;
      if (abort) state <= IDLE;
      else case (state)
        IDLE: if (start && ok) begin
          state <= SEEK;
          lo <= loLimit;
          hi <= hiLimit;
          nsw <= numSweeps;
          sweepCnt <= '0;
        end
        SEEK: if (countIn == lo) state <= UP;
        UP: if (countIn == hi) state <= DOWN;
        DOWN: if (countIn == lo) begin
          sweepCnt <= cnt_nxt;
          state <= cnt_nxt == nsw ? DONE : UP;
        end
        default: state <= IDLE;
      endcase
    end
  // Turnaround cycles (countIn at the target limit) hold the counter still.
  always_comb begin
    busy = state != IDLE;
    done = state == DONE && !abort;
    upDown = state == SEEK ? countIn < lo : state != DOWN;
    enable = !abort && ((state == SEEK || state == DOWN) ? countIn != lo : state == UP && countIn != hi);
  end
endmodule

// File: doc/counter_sweep_ctrl.md
COUNTER_SWEEP_CTRL -- requirements
Module: counter_sweep_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, width of counter value and limits.
REQ-002 SHALL have parameter SWEEP_W, default 4, width of sweep-count fields.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to begin a sweep job; sampled only in IDLE.
REQ-006 abort  input  1  terminate job; return to IDLE.
REQ-007 loLimit  input  WIDTH  lower turnaround value; latched at accepted start.
REQ-008 hiLimit  input  WIDTH  upper turnaround value; latched at accepted start.
REQ-009 numSweeps  input  SWEEP_W  full lo->hi->lo sweeps to run; latched at accepted start.
REQ-010 countIn  input  WIDTH  current value of the controlled up/down counter (its countOut).
REQ-011 enable  output  1  count-enable to the counter.
REQ-012 upDown  output  1  direction to the counter; 1 = increment, 0 = decrement.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle pulse on job completion.
REQ-015 error  output  1  one-cycle pulse on rejected start.
REQ-016 sweepCnt  output  SWEEP_W  completed sweeps in current/last job.

Function
REQ-017 States SHALL be IDLE, SEEK, UP, DOWN, DONE; enable/upDown SHALL be combinational from state, latched limits and countIn.
REQ-018 IDLE: enable=0, upDown=1; start with loLimit<hiLimit and numSweeps!=0 -> latch inputs, clear sweepCnt, go SEEK.
REQ-019 IDLE: start with loLimit>=hiLimit or numSweeps==0 -> error=1 next cycle, stay IDLE, latched values and sweepCnt unchanged.
REQ-020 start SHALL be ignored in all states except IDLE.
REQ-021 SEEK: enable=(countIn!=lo), upDown=(countIn<lo); countIn==lo -> UP.
REQ-022 UP: upDown=1, enable=(countIn!=hi); countIn==hi -> DOWN.
REQ-023 DOWN: upDown=0, enable=(countIn!=lo); countIn==lo -> sweepCnt+1, then DONE if new sweepCnt==numSweeps else UP.
REQ-024 Turnaround cycle (equality seen) SHALL drive enable=0; no overshoot past lo or hi permitted.
REQ-025 DONE: enable=0, done=1 for exactly one cycle, then IDLE; busy=1 in DONE.
REQ-026 abort in any non-IDLE state: enable=0 combinationally that same cycle, next state IDLE, sweepCnt held, no done pulse.
REQ-027 abort and start in same IDLE cycle: abort SHALL win; start dropped, no error.
REQ-028 Comparisons unsigned, WIDTH bits; no wrap-around permitted since lo<hi enforced.
REQ-029 sweepCnt SHALL hold its final value in IDLE until next accepted start.

Reset
REQ-030 rst high SHALL immediately force IDLE: enable=0, upDown=1, busy=0, done=0, error=0, sweepCnt=0, latched limits=0.
REQ-031 rst asserted mid-job SHALL drop enable asynchronously; no done pulse after release.
REQ-032 First start SHALL be accepted on the first rising edge after rst deasserts.

Verification
REQ-033 countIn=0, start lo=2 hi=5 numSweeps=1 -> SEEK cycles 1-3, UP 4-7, DOWN 8-11, done=1 cycle 12, sweepCnt=1, countIn=2 final.
REQ-034 countIn=9, lo=3 hi=6 numSweeps=2 -> SEEK decrements 9->3 (upDown=0), two sweeps 3->6->3, done once, sweepCnt=2, counter never outside 3..6.
REQ-035 start lo=7 hi=7 (and separately numSweeps=0) -> error pulse 1 cycle, busy stays 0, enable stays 0.
REQ-036 abort during UP at countIn=4 -> enable=0 same cycle, IDLE next, no done, countIn frozen at 4.
REQ-037 rst pulse during DOWN -> enable=0 immediately, all outputs at reset values, no done after release.
REQ-038 start pulsed again while busy -> ignored; job completes with original limits and sweep count.
